// File: rtl/credit_return_fifo_if.sv
// Handshake bundle between the credit sender/consumer side and the
// receive-side credit return FIFO.
interface credit_return_fifo_if #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int COUNT_SZ   = 10
);
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic                  enq__ENA;
   logic [DATA_WIDTH-1:0] enq_v;
   logic                  enq__RDY;
   logic                  deq__ENA;
   logic                  deq__RDY;
   logic [DATA_WIDTH-1:0] first;
   logic                  first__RDY;
   logic                  credit__ENA;
   logic [COUNT_SZ-1:0]   credit_v;
   logic [OCC_W-1:0]      occupancy;
   logic                  overflow;

   // Environment side: pushes words, pops words, receives credits.
   modport master (
      output enq__ENA, enq_v, deq__ENA,
      input  enq__RDY, deq__RDY, first, first__RDY,
             credit__ENA, credit_v, occupancy, overflow
   );

   // FIFO side.
   modport slave (
      input  enq__ENA, enq_v, deq__ENA,
      output enq__RDY, deq__RDY, first, first__RDY,
             credit__ENA, credit_v, occupancy, overflow
   );
endinterface

// File: rtl/credit_return_fifo.sv
// Receive-side buffer of a credit flow-control link. Words pushed by the
// sender are queued for the local consumer; each dequeued word earns back
// one credit. Credits are batched and returned once BATCH are pending, or
// flushed after TIMEOUT idle cycles. The full depth is advertised once
// after every reset.
module credit_return_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int COUNT_SZ   = 10,
   parameter int BATCH      = 4,
   parameter int TIMEOUT    = 15
) (
   input logic                 CLK,
   input logic                 nRST,
   credit_return_fifo_if.slave io
);
   localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W   = $clog2(DEPTH + 1);
   localparam int TIMER_W = $clog2(TIMEOUT + 1);

   localparam logic [PTR_W-1:0]    PTR_LAST  = PTR_W'(DEPTH - 1);
   localparam logic [OCC_W-1:0]    OCC_FULL  = OCC_W'(DEPTH);
   localparam logic [COUNT_SZ-1:0] CRED_INIT = COUNT_SZ'(DEPTH);
   localparam logic [COUNT_SZ-1:0] CRED_BAT  = COUNT_SZ'(BATCH);
   localparam logic [TIMER_W-1:0]  TIMER_MAX = TIMER_W'(TIMEOUT);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   // Storage is deliberately left unreset; only pointers define validity.
   logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

   logic [PTR_W-1:0]    rd_ptr_reg, wr_ptr_reg;
   logic [PTR_W-1:0]    rd_ptr_next, wr_ptr_next;
   logic [OCC_W-1:0]    occ_reg, occ_next;
   logic                ovf_reg;
   state_t              state_reg;
   logic [COUNT_SZ-1:0] pending_reg, pending_next;
   logic [TIMER_W-1:0]  timer_reg;
   logic                credit_ena_reg;
   logic [COUNT_SZ-1:0] credit_v_reg;

   logic deq_fire, enq_fire, flush;

   // Handshake decode, pointer wrap and credit flush decision.
   always_comb begin
      deq_fire     = io.deq__ENA & (occ_reg != '0);
      // A full buffer still accepts a push when a pop frees the slot this cycle.
      enq_fire     = io.enq__ENA & ((occ_reg < OCC_FULL) | deq_fire);
      rd_ptr_next  = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
      wr_ptr_next  = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
      occ_next     = occ_reg;
      case ({enq_fire, deq_fire})
         2'b10:   occ_next = occ_reg + 1'b1;
         2'b01:   occ_next = occ_reg - 1'b1;
         default: occ_next = occ_reg;
      endcase
      pending_next = pending_reg + COUNT_SZ'(deq_fire);
      flush        = (pending_next >= CRED_BAT) |
                     ((pending_next != '0) & (timer_reg == TIMER_MAX));
   end

   assign io.enq__RDY    = 1'b1;
   assign io.deq__RDY    = (occ_reg != '0);
   assign io.first__RDY  = (occ_reg != '0);
   assign io.first       = mem_reg[rd_ptr_reg];
   assign io.occupancy   = occ_reg;
   assign io.overflow    = ovf_reg;
   assign io.credit__ENA = credit_ena_reg;
   assign io.credit_v    = credit_v_reg;

   // Write accepted words into the circular buffer.
   always_ff @(posedge CLK) begin
      if (nRST && enq_fire)
         mem_reg[wr_ptr_reg] <= io.enq_v;
   end

   // Pointer, occupancy and sticky overflow bookkeeping.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         occ_reg    <= '0;
         ovf_reg    <= 1'b0;
      end else begin
         if (enq_fire) wr_ptr_reg <= wr_ptr_next;
         if (deq_fire) rd_ptr_reg <= rd_ptr_next;
         occ_reg <= occ_next;
         if (io.enq__ENA && !enq_fire) ovf_reg <= 1'b1;
      end
   end

   // Credit FSM: advertise DEPTH once, then batch/timeout the returned credits.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_reg      <= ST_INIT;
         pending_reg    <= '0;
         timer_reg      <= '0;
         credit_ena_reg <= 1'b0;
         credit_v_reg   <= '0;
      end else begin
         case (state_reg)
            ST_INIT: begin
               credit_ena_reg <= 1'b1;
               credit_v_reg   <= CRED_INIT;
               pending_reg    <= pending_next;
               // Start ageing any pop that already landed here.
               timer_reg      <= (pending_next != '0) ? TIMER_W'(1) : '0;
               state_reg      <= ST_RUN;
            end
            ST_RUN: begin
               if (flush) begin
                  credit_ena_reg <= 1'b1;
                  credit_v_reg   <= pending_next;
                  pending_reg    <= '0;
                  timer_reg      <= '0;
               end else begin
                  credit_ena_reg <= 1'b0;
                  credit_v_reg   <= '0;
                  pending_reg    <= pending_next;
                  if (pending_next == '0)
                     timer_reg <= '0;
                  else if (timer_reg != TIMER_MAX)
                     timer_reg <= timer_reg + 1'b1;
               end
            end
            default: state_reg <= ST_INIT;
         endcase
      end
   end
endmodule

// File: tb/tb_credit_return_fifo.sv
// Scoreboard bench for credit_return_fifo. The driver applies stimulus just
// after each rising edge and updates a behavioural model; expected words and
// credit pulses are queued, and an independent monitor at the falling edge
// compares DUT outputs against them.
module tb_credit_return_fifo;
   localparam int DW      = 32;
   localparam int DEPTH   = 8;
   localparam int CS      = 10;
   localparam int BATCH   = 4;
   localparam int TIMEOUT = 15;

   logic CLK  = 1'b0;
   logic nRST = 1'b0;
   always #5 CLK = ~CLK;

   credit_return_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .COUNT_SZ(CS)) io ();

   credit_return_fifo #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .COUNT_SZ(CS), .BATCH(BATCH), .TIMEOUT(TIMEOUT)
   ) dut (
      .CLK (CLK),
      .nRST(nRST),
      .io  (io)
   );

   typedef struct {int cyc; int val;} cred_t;

   cred_t          cred_q[$];
   logic [DW-1:0]  data_q[$];
   int             checks = 0;
   int             errors = 0;
   int             cyc    = 0;

   // Per-cycle expectations published by the driver.
   bit snap_valid = 1'b0;
   int exp_occ    = 0;
   bit exp_ovf    = 1'b0;

   // Behavioural model state.
   int m_count = 0;
   bit m_ovf   = 1'b0;
   bit m_init  = 1'b0;
   int m_pend  = 0;
   int m_first = 0;
   bit m_live  = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_credit(input int at, input int val);
      cred_t c;
      c.cyc = at;
      c.val = val;
      cred_q.push_back(c);
   endtask

   // One clock cycle of stimulus plus the reference model's view of it.
   task automatic step(input bit rst_n, input bit enq, input logic [DW-1:0] d, input bit deq);
      bit dfire;
      bit efire;
      @(posedge CLK);
      #1;
      cyc++;
      snap_valid = m_live;
      exp_occ    = m_count;
      exp_ovf    = m_ovf;
      nRST        = rst_n;
      io.enq__ENA = enq;
      io.enq_v    = d;
      io.deq__ENA = deq;
      if (!rst_n) begin
         m_count = 0;
         m_ovf   = 1'b0;
         m_init  = 1'b1;
         m_pend  = 0;
         m_live  = 1'b1;
         data_q.delete();
      end else if (m_live) begin
         dfire = deq && (m_count > 0);
         efire = enq && ((m_count < DEPTH) || dfire);
         if (enq && !efire) m_ovf = 1'b1;
         if (efire) data_q.push_back(d);
         m_count = m_count + int'(efire) - int'(dfire);
         if (dfire) begin
            if (m_pend == 0) m_first = cyc;
            m_pend++;
         end
         if (m_init) begin
            push_credit(cyc + 1, DEPTH);
            m_init = 1'b0;
         end else if (m_pend >= BATCH || (m_pend != 0 && cyc - m_first >= TIMEOUT)) begin
            // Credits leave once BATCH accumulate or the oldest has aged TIMEOUT cycles.
            push_credit(cyc + 1, m_pend);
            m_pend = 0;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0);
   endtask

   // Monitor: compares every registered output once per cycle.
   initial begin
      forever begin
         @(negedge CLK);
         if (snap_valid) begin
            check("occupancy",  io.occupancy,  exp_occ);
            check("overflow",   io.overflow,   exp_ovf);
            check("deq_rdy",    io.deq__RDY,   exp_occ != 0);
            check("first_rdy",  io.first__RDY, exp_occ != 0);
            check("enq_rdy",    io.enq__RDY,   1'b1);
            if (nRST && io.deq__ENA && exp_occ != 0) begin
               if (data_q.size() == 0) check("first_underflow", 1'b1, 1'b0);
               else check("first", io.first, data_q.pop_front());
            end
            while (cred_q.size() != 0 && cred_q[0].cyc < cyc) begin
               check("credit_missed_cycle", cred_q[0].cyc, cyc);
               void'(cred_q.pop_front());
            end
            if (io.credit__ENA === 1'b1) begin
               if (cred_q.size() == 0 || cred_q[0].cyc != cyc)
                  check("credit_unexpected", io.credit_v, 0);
               else
                  check("credit_value", io.credit_v, cred_q.pop_front().val);
            end else begin
               check("credit_ena", io.credit__ENA, 1'b0);
               check("credit_v_idle", io.credit_v, 0);
               if (cred_q.size() != 0 && cred_q[0].cyc == cyc) begin
                  check("credit_missing", 0, cred_q[0].val);
                  void'(cred_q.pop_front());
               end
            end
         end
      end
   end

   // Driver: directed scenarios followed by randomized traffic.
   initial begin
      io.enq__ENA = 1'b0;
      io.enq_v    = '0;
      io.deq__ENA = 1'b0;

      // Reset, then idle: the initial DEPTH advertisement must appear once.
      step(1'b0, 1'b0, '0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0);
      idle(20);

      // Three words through, returned on timeout.
      step(1'b1, 1'b1, 32'hA, 1'b0);
      step(1'b1, 1'b1, 32'hB, 1'b0);
      step(1'b1, 1'b1, 32'hC, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b1);
      idle(20);

      // Four pops back-to-back return one batch.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, DW'(32'h100 + i), 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b1);
      idle(20);

      // Fill, overflow, then simultaneous push/pop while full, then drain.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, DW'(32'h200 + i), 1'b0);
      step(1'b1, 1'b1, 32'hDEAD, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, DW'(32'h300 + i), 1'b1);
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, '0, 1'b1);
      idle(20);

      // Reset discards pending credits and re-advertises DEPTH.
      step(1'b1, 1'b1, 32'h400, 1'b0);
      step(1'b1, 1'b1, 32'h401, 1'b0);
      step(1'b1, 1'b0, '0, 1'b1);
      step(1'b1, 1'b0, '0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0);
      idle(20);

      // Interleaved random traffic that never overflows, across pointer wrap.
      for (int i = 0; i < 40; i++)
         step(1'b1, ($urandom_range(0, 1) == 1) && (m_count < DEPTH), DW'($urandom), $urandom_range(0, 1) == 1);
      idle(20);

      // Unconstrained random traffic with occasional overflow and reset.
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) == 0);
      idle(30);

      @(negedge CLK);
      #1;
      check("credits_outstanding", cred_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
